// File: rtl/riscv_pkg.sv
// Shared definitions for the core and its memory arbiter.
package riscv_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    // Opcodes of the instruction subset the core implements
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_ALU = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/riscv_mem_arbiter.sv
// Serialises instruction-fetch and data accesses onto one single-ported
// memory. Data has priority; a saturating counter lets a pending fetch win
// after STARVE_MAX consecutive data grants.
module riscv_mem_arbiter
    import riscv_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              err
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    arb_state_t state, state_nxt;
    logic       gnt_d;
    logic [3:0] starve_cnt;
    logic       fetch_wins;
    logic       grant;
    logic       mem_en_nxt, if_ready_nxt, d_ready_nxt, busy_nxt;

    // Fetch wins when it is alone or when data has starved it long enough
    assign fetch_wins = if_req && (!d_req || starve_cnt == STARVE_LIM);
    assign grant      = (state == IDLE) && (if_req || d_req);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (if_req || d_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (mem_valid) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode from the next state, so every strobe leaves a flop
    always_comb begin
        mem_en_nxt   = (state_nxt == ISSUE);
        if_ready_nxt = (state_nxt == DONE) && !gnt_d;
        d_ready_nxt  = (state_nxt == DONE) &&  gnt_d;
        busy_nxt     = (state_nxt != IDLE);
    end

    // Registered strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_en   <= 1'b0;
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            mem_en   <= mem_en_nxt;
            if_ready <= if_ready_nxt;
            d_ready  <= d_ready_nxt;
            busy     <= busy_nxt;
        end
    end

    // Grant: latch winner and payload straight into the memory-side
    // registers; they hold until the next grant, mem_we doubles as the
    // latched store flag for the completion path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_d      <= 1'b0;
            starve_cnt <= 4'd0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else if (grant) begin
            gnt_d <= !fetch_wins;
            if (fetch_wins) begin
                starve_cnt <= 4'd0;
                mem_we     <= 1'b0;
                mem_addr   <= {2'b00, if_addr[ADDR_W-1:2]};
            end else begin
                if (if_req && starve_cnt != 4'hF) starve_cnt <= starve_cnt + 4'd1;
                mem_we    <= d_we;
                mem_addr  <= {2'b00, d_addr[ADDR_W-1:2]};
                mem_wdata <= d_wdata;
            end
        end
    end

    // Response capture; stores leave d_rdata untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rdata <= '0;
            d_rdata  <= '0;
        end else if (state == WAIT && mem_valid) begin
            if (!gnt_d)       if_rdata <= mem_rdata;
            else if (!mem_we) d_rdata  <= mem_rdata;
        end
    end

    // Sticky error on a response nobody asked for
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          err <= 1'b0;
        else if (mem_valid && state != WAIT) err <= 1'b1;
    end

endmodule
